// File: rtl/cache_fill_ctrl_pkg.sv
// Shared definitions for the cache fill controller: FSM state encoding,
// the word size in bytes, and block-offset/word-index width helpers.
package cache_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FILL  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 2;

  // Bits of a byte address that select a byte inside one cache block.
  function automatic int offset_bits(input int words_per_block);
    return $clog2(words_per_block) + $clog2(BYTES_PER_WORD);
  endfunction

  function automatic int word_idx_bits(input int words_per_block);
    return (words_per_block > 1) ? $clog2(words_per_block) : 1;
  endfunction

  function automatic int grant_bits(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Bundle of cache-channel, write-through and main-memory signals around the
// fill controller; master = controller side, slave = caches + memory.
interface cache_fill_ctrl_if
  import cache_fill_ctrl_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
);
  localparam int WIDX = word_idx_bits(WORDS_PER_BLOCK);

  // Handshakes: miss_req[i] is a level held by cache i until fill_tag_we[i]
  // is seen; busy[i] stalls that cache. wr_req is held until the one-cycle
  // wr_ack pulse. Memory accepts one address per cycle while mem_en is high
  // and answers each read with mem_data_valid after a fixed latency.
  logic [NUM_PORTS-1:0]        miss_req;
  logic [NUM_PORTS*ADDR_W-1:0] miss_addr;
  logic                        wr_req;
  logic [ADDR_W-1:0]           wr_addr;
  logic [DATA_W-1:0]           wr_data;
  logic                        wr_ack;
  logic [NUM_PORTS-1:0]        busy;
  logic [NUM_PORTS-1:0]        fill_data_we;
  logic [NUM_PORTS-1:0]        fill_tag_we;
  logic [WIDX-1:0]             fill_word;
  logic [DATA_W-1:0]           fill_data;
  logic                        mem_en;
  logic                        mem_wr;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_data_in;
  logic [DATA_W-1:0]           mem_data_out;
  logic                        mem_data_valid;

  modport master (
    input  miss_req, miss_addr, wr_req, wr_addr, wr_data,
    input  mem_data_out, mem_data_valid,
    output wr_ack, busy, fill_data_we, fill_tag_we, fill_word, fill_data,
    output mem_en, mem_wr, mem_addr, mem_data_in
  );

  modport slave (
    output miss_req, miss_addr, wr_req, wr_addr, wr_data,
    output mem_data_out, mem_data_valid,
    input  wr_ack, busy, fill_data_we, fill_tag_we, fill_word, fill_data,
    input  mem_en, mem_wr, mem_addr, mem_data_in
  );

endinterface

// File: rtl/cache_fill_ctrl_fill_arbiter.sv
// Miss-channel arbiter. Build macro FILL_RR_EN selects round-robin (pointer
// moves past the channel whose fill completed); otherwise lowest index wins.
module fill_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int GW        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 advance_i,
  input  logic [GW-1:0]        adv_idx_i,
  output logic [GW-1:0]        grant_o,
  output logic                 valid_o
);

`ifdef FILL_RR_EN
  logic [GW-1:0] ptr_q;
  logic [GW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (adv_idx_i == GW'(NUM_PORTS - 1)) ? '0 : adv_idx_i + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Search upward from the pointer, wrapping at NUM_PORTS.
  always_comb begin
    int idx;
    grant_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!valid_o && req_i[idx]) begin
        grant_o = GW'(idx);
        valid_o = 1'b1;
      end
    end
  end
`else
  logic unused_rr_inputs;
  assign unused_rr_inputs = ^{clk, rst, advance_i, adv_idx_i};

  // Descending scan so the lowest requesting index is the last to write.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o = GW'(i);
        valid_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache fill / memory arbitration controller: serialises write-through stores
// and block fills for NUM_PORTS caches. Build macro FILL_RR_EN: round-robin fills.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  cache_fill_ctrl_if.master bus,
  output state_e            dbg_state_o
);

  localparam int WIDX  = word_idx_bits(WORDS_PER_BLOCK);
  localparam int OFF_W = offset_bits(WORDS_PER_BLOCK);
  localparam int GW    = grant_bits(NUM_PORTS);
  localparam logic [WIDX-1:0]   LAST_WORD = WIDX'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [WIDX-1:0]   issue_q, issue_d;
  logic [WIDX-1:0]   ret_q,   ret_d;
  logic [ADDR_W-1:0] base_q,  base_d;

  logic [GW-1:0]        arb_idx;
  logic                 arb_valid;
  logic [ADDR_W-1:0]    sel_addr;
  logic [ADDR_W-1:0]    fill_addr;
  logic [NUM_PORTS-1:0] grant_oh;
  logic                 fill_active;
  logic                 fill_done;

  logic                 wr_ack;
  logic                 mem_en;
  logic                 mem_wr;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_data_in;
  logic [NUM_PORTS-1:0] fill_data_we;
  logic [NUM_PORTS-1:0] fill_tag_we;
  logic [NUM_PORTS-1:0] busy;

  fill_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .GW        (GW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.miss_req),
    .advance_i (fill_done),
    .adv_idx_i (grant_q),
    .grant_o   (arb_idx),
    .valid_o   (arb_valid)
  );

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_idx == GW'(i)) sel_addr = bus.miss_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign fill_addr   = base_q + ADDR_W'(issue_q) * ADDR_W'(BYTES_PER_WORD);
  assign grant_oh    = NUM_PORTS'(1) << grant_q;
  assign fill_active = (state_q == S_FILL) || (state_q == S_DRAIN);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    issue_d      = issue_q;
    ret_d        = ret_q;
    base_d       = base_q;
    wr_ack       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    fill_data_we = '0;
    fill_tag_we  = '0;
    fill_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.wr_req) begin
          state_d = S_WRITE;
        end else if (arb_valid) begin
          state_d = S_FILL;
          grant_d = arb_idx;
          base_d  = sel_addr & ~OFF_MASK;
          issue_d = '0;
          ret_d   = '0;
        end
      end
      S_WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = bus.wr_addr;
        mem_data_in = bus.wr_data;
        wr_ack      = 1'b1;
        state_d     = S_IDLE;
      end
      S_FILL: begin
        mem_en   = 1'b1;
        mem_addr = fill_addr;
        issue_d  = issue_q + 1'b1;
        if (issue_q == LAST_WORD) state_d = S_DRAIN;
      end
      S_DRAIN: ;
      default: state_d = S_IDLE;
    endcase

    // Returns can overlap issuing; the last one closes the fill from either state.
    if (fill_active && bus.mem_data_valid) begin
      fill_data_we = grant_oh;
      ret_d        = ret_q + 1'b1;
      if (ret_q == LAST_WORD) begin
        fill_tag_we = grant_oh;
        fill_done   = 1'b1;
        state_d     = S_IDLE;
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      busy[i] = bus.miss_req[i] | (fill_active & (grant_q == GW'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      issue_q <= '0;
      ret_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      base_q  <= base_d;
    end
  end

  assign bus.wr_ack       = wr_ack;
  assign bus.busy         = busy;
  assign bus.fill_data_we = fill_data_we;
  assign bus.fill_tag_we  = fill_tag_we;
  assign bus.fill_word    = ret_q;
  assign bus.fill_data    = bus.mem_data_out;
  assign bus.mem_en       = mem_en;
  assign bus.mem_wr       = mem_wr;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_data_in  = mem_data_in;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl with a 4-cycle pipelined memory model.
module tb_cache_fill_ctrl;
  import cache_fill_ctrl_pkg::*;

  localparam int NP = 2, WPB = 8, AW = 16, DW = 16;
  localparam logic [15:0] DATA_XOR = 16'hC3A5;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     cyc = 0;
  state_e dbg_state;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_fill_ctrl_if #(.NUM_PORTS(NP), .WORDS_PER_BLOCK(WPB), .ADDR_W(AW), .DATA_W(DW)) bus ();

  cache_fill_ctrl #(.NUM_PORTS(NP), .WORDS_PER_BLOCK(WPB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Memory: address issued in cycle t returns in cycle t+4; data = addr ^ DATA_XOR.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4] = '{default: 16'h0};
  always @(posedge clk) begin
    pv    <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
    pa[0] <= bus.mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign bus.mem_data_valid = pv[3];
  assign bus.mem_data_out   = pv[3] ? (pa[3] ^ DATA_XOR) : 16'h0;

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [32:0] exp_mem_q[$];   // {wr, addr, wdata}
  logic [20:0] exp_fill_q[$];  // {tag, ch, word, data}
  int          tag_cyc [2] = '{0, 0};
  int          ack_cyc = 0;
  int          watch_cyc = 0;
  logic [15:0] watch_addr = 16'hFFFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mem_mon
    logic [32:0] obs;
    logic [32:0] exp;
    if (bus.mem_en || bus.wr_ack) begin
      obs = {bus.mem_wr, bus.mem_addr, bus.mem_wr ? bus.mem_data_in : 16'h0};
      if (bus.mem_en && bus.mem_addr == watch_addr) watch_cyc = cyc;
      if (bus.wr_ack) ack_cyc = cyc;
      if (exp_mem_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL mem_unexpected: got %0h, expected no memory transaction", obs);
      end else begin
        exp = exp_mem_q.pop_front();
        check("mem_txn", 64'(obs), 64'(exp));
        check("wr_ack", 64'(bus.wr_ack), 64'(exp[32]));
      end
    end
  end

  always @(negedge clk) begin : fill_mon
    logic [20:0] obs;
    logic [20:0] exp;
    if (bus.fill_data_we != '0 || bus.fill_tag_we != '0) begin
      obs = {|bus.fill_tag_we, bus.fill_data_we[1], bus.fill_word, bus.fill_data};
      check("tag_without_data", 64'(bus.fill_tag_we & ~bus.fill_data_we), 64'(0));
      check("data_we_onehot", 64'($onehot(bus.fill_data_we)), 64'(1));
      if (|bus.fill_tag_we) tag_cyc[bus.fill_data_we[1]] = cyc;
      if (exp_fill_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL fill_unexpected: got %0h, expected no fill write", obs);
      end else begin
        exp = exp_fill_q.pop_front();
        check("fill_write", 64'(obs), 64'(exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_fill(input int ch, input logic [15:0] addr);
    logic [15:0] a;
    for (int k = 0; k < WPB; k++) begin
      a = (addr & 16'hFFF0) + 16'(2 * k);
      exp_mem_q.push_back({1'b0, a, 16'h0});
      exp_fill_q.push_back({(k == WPB - 1), 1'(ch), 3'(k), a ^ DATA_XOR});
    end
  endtask

  // Per-channel cache: drops miss_req on its tag write (hold_tags==0), or holds
  // every request until hold_tags tag writes have been seen.
  task automatic wait_drop(input logic [1:0] mask, input int hold_tags,
                           output int busy_gaps, output int acks);
    logic [1:0] pending;
    int tags;
    pending = mask;
    tags = 0;
    busy_gaps = 0;
    acks = 0;
    for (int t = 0; t < 400 && pending != 2'b00; t++) begin
      @(negedge clk);
      for (int ch = 0; ch < NP; ch++) if (pending[ch] && !bus.busy[ch]) busy_gaps++;
      if (bus.wr_ack) acks++;
      if (hold_tags == 0) begin
        for (int ch = 0; ch < NP; ch++) begin
          if (pending[ch] && bus.fill_tag_we[ch]) begin
            bus.miss_req[ch] = 1'b0;
            pending[ch] = 1'b0;
          end
        end
      end else if (|bus.fill_tag_we) begin
        tags++;
        if (tags == hold_tags) begin
          bus.miss_req = '0;
          pending = 2'b00;
        end
      end
    end
    check("fill_timeout", 64'(pending), 64'(0));
    bus.miss_req = '0;
  endtask

  task automatic wait_ack();
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (bus.wr_ack) seen = 1'b1;
    end
    check("ack_timeout", 64'(seen), 64'(1));
    bus.wr_req = 1'b0;
  endtask

  task automatic set_miss_addr(input int ch, input logic [15:0] a);
    bus.miss_addr[ch*AW +: AW] = a;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int gaps, acks, seen;
    bus.miss_req = '0;
    bus.miss_addr = '0;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({bus.mem_en, bus.mem_wr, bus.wr_ack, bus.fill_data_we,
          bus.fill_tag_we, bus.fill_word, bus.busy, bus.mem_addr}), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(S_IDLE));
    rst = 1'b0;

    // 1: single miss on I-cache at 0x1236
    @(negedge clk);
    push_fill(1, 16'h1236);
    set_miss_addr(1, 16'h1236);
    bus.miss_req = 2'b10;
    #1 check("busy_same_cycle", 64'(bus.busy), 64'(2'b10));
    wait_drop(2'b10, 0, gaps, acks);
    @(negedge clk);
    check("busy_after_drop", 64'(bus.busy), 64'(0));
    check("idle_after_fill", 64'(dbg_state), 64'(S_IDLE));

    // 2: both channels miss together; ch0 first, ch1 one IDLE cycle later
    push_fill(0, 16'h0040);
    push_fill(1, 16'h2000);
    watch_addr = 16'h2000;
    set_miss_addr(0, 16'h0040);
    set_miss_addr(1, 16'h2000);
    bus.miss_req = 2'b11;
    wait_drop(2'b11, 0, gaps, acks);
    check("busy1_held", 64'(gaps), 64'(0));
    @(negedge clk);
    check("ch1_issue_gap", 64'(watch_cyc - tag_cyc[0]), 64'(2));

    // 3: store and D-miss in the same cycle; store goes first
    exp_mem_q.push_back({1'b1, 16'h0100, 16'hBEEF});
    push_fill(0, 16'h0300);
    watch_addr = 16'h0300;
    set_miss_addr(0, 16'h0300);
    bus.wr_addr = 16'h0100;
    bus.wr_data = 16'hBEEF;
    bus.wr_req = 1'b1;
    bus.miss_req = 2'b01;
    wait_ack();
    wait_drop(2'b01, 0, gaps, acks);
    @(negedge clk);
    check("fill_after_write", 64'(watch_cyc - ack_cyc), 64'(2));

    // 4: reset after three returned words, then a fresh miss
    push_fill(0, 16'h0500);
    set_miss_addr(0, 16'h0500);
    bus.miss_req = 2'b01;
    seen = 0;
    for (int t = 0; t < 100 && seen == 0; t++) begin
      @(negedge clk);
      if (bus.fill_data_we[0] && bus.fill_word == 3'd2) seen = 1;
    end
    check("third_word_seen", 64'(seen), 64'(1));
    rst = 1'b1;
    bus.miss_req = '0;
    @(posedge clk);
    #1;
    check("issued_before_reset", 64'(exp_mem_q.size()), 64'(1));
    check("returned_before_reset", 64'(exp_fill_q.size()), 64'(5));
    exp_mem_q.delete();
    exp_fill_q.delete();
    @(negedge clk);
    check("strobes_after_reset", 64'({bus.mem_en, bus.wr_ack, bus.fill_data_we,
          bus.fill_tag_we, bus.fill_word}), 64'(0));
    check("state_after_reset", 64'(dbg_state), 64'(S_IDLE));
    rst = 1'b0;
    repeat (8) @(negedge clk);
    push_fill(0, 16'h0800);
    set_miss_addr(0, 16'h0800);
    bus.miss_req = 2'b01;
    wait_drop(2'b01, 0, gaps, acks);

    // 5: store raised mid-fill waits for the tag write plus one IDLE cycle
    push_fill(0, 16'h0A10);
    set_miss_addr(0, 16'h0A10);
    bus.miss_req = 2'b01;
    repeat (3) @(negedge clk);
    exp_mem_q.push_back({1'b1, 16'h0200, 16'h1234});
    bus.wr_addr = 16'h0200;
    bus.wr_data = 16'h1234;
    bus.wr_req = 1'b1;
    wait_drop(2'b01, 0, gaps, acks);
    check("no_ack_during_fill", 64'(acks), 64'(0));
    wait_ack();
    @(negedge clk);
    check("ack_gap", 64'(ack_cyc - tag_cyc[0]), 64'(2));

    // 6: both channels re-requesting continuously for four fills
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef FILL_RR_EN
    push_fill(0, 16'h3006);
    push_fill(1, 16'h400A);
    push_fill(0, 16'h3006);
    push_fill(1, 16'h400A);
`else
    for (int k = 0; k < 4; k++) push_fill(0, 16'h3006);
`endif
    set_miss_addr(0, 16'h3006);
    set_miss_addr(1, 16'h400A);
    bus.miss_req = 2'b11;
    wait_drop(2'b11, 4, gaps, acks);
    check("busy_during_rerequest", 64'(gaps), 64'(0));

    repeat (10) @(negedge clk);
    check("mem_q_drained", 64'(exp_mem_q.size()), 64'(0));
    check("fill_q_drained", 64'(exp_fill_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
